// File: rtl/hdmi_acr_if.sv
// Decoded data-island packet bus from the packet decoder into the ACR receiver.
// One beat per packet; packet_valid qualifies header and subpackets for that cycle.
interface hdmi_acr_if;
  logic             packet_valid;
  logic [23:0]      header;
  logic [3:0][55:0] sub;

  modport master (output packet_valid, output header, output sub);
  modport slave  (input  packet_valid, input  header, input  sub);
endinterface

// File: rtl/hdmi_acr_receiver.sv
// HDMI ACR sink: validates ACR packets, locks onto N/CTS and regenerates a 128*fs
// clock enable plus an fs sample strobe from the pixel clock via a fractional accumulator.
module hdmi_acr_receiver #(
  parameter int unsigned LOCK_COUNT     = 2,
  parameter int unsigned CTS_TOLERANCE  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic          i_clk_pixel,
  input  logic          i_reset,
  hdmi_acr_if.slave     i_pkt,
  output logic [19:0]   o_n_out,
  output logic [19:0]   o_cts_out,
  output logic          o_locked,
  output logic          o_acr_error,
  output logic          o_clk_audio_en,
  output logic          o_sample_en
);

  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_MAX = TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

  state_e          r_state;
  logic [19:0]     r_cand_n;
  logic [19:0]     r_cand_cts;
  logic [3:0]      r_match;
  logic [TO_W-1:0] r_timeout;
  logic [19:0]     r_n_out;
  logic [19:0]     r_cts_out;
  logic            r_locked;
  logic            r_acr_error;
  logic [19:0]     r_acc;
  logic [6:0]      r_div;
  logic            r_clk_audio_en;
  logic            r_sample_en;

  logic [55:0] w_sub0;
  logic [19:0] w_n;
  logic [19:0] w_cts;
  logic        w_is_acr;
  logic        w_malformed;
  logic        w_pkt_ok;
  logic        w_cand_eq;
  logic [19:0] w_cts_diff;
  logic        w_in_tol;
  logic        w_timeout;
  logic [3:0]  w_match_inc;
  logic [3:0]  w_match_next;
  logic        w_lock_now;
  logic [20:0] w_sum;
  logic [20:0] w_sum_sub;
  logic        w_unused;

  assign w_unused = ^i_pkt.header[23:8];

  assign w_sub0 = i_pkt.sub[0];
  assign w_n    = {w_sub0[35:32], w_sub0[47:40], w_sub0[55:48]};
  assign w_cts  = {w_sub0[11:8], w_sub0[23:16], w_sub0[31:24]};

  assign w_is_acr    = i_pkt.packet_valid && (i_pkt.header[7:0] == 8'h01);
  assign w_malformed = (i_pkt.sub[1] != w_sub0) || (i_pkt.sub[2] != w_sub0) ||
                       (i_pkt.sub[3] != w_sub0) ||
                       (|{w_sub0[39:36], w_sub0[15:12], w_sub0[7:0]}) ||
                       (w_n == 20'd0) || (w_cts == 20'd0) || (w_n >= w_cts);
  assign w_pkt_ok    = w_is_acr && !w_malformed;

  assign w_cand_eq  = (w_n == r_cand_n) && (w_cts == r_cand_cts);
  assign w_cts_diff = (w_cts >= r_cts_out) ? (w_cts - r_cts_out) : (r_cts_out - w_cts);
  assign w_in_tol   = (w_n == r_n_out) && (w_cts_diff <= CTS_TOLERANCE[19:0]);
  assign w_timeout  = (r_timeout == TO_MAX[TO_W-1:0]);

  // Unlocked always starts a fresh candidate; acquire only counts exact repeats.
  assign w_match_inc  = (r_match == 4'hF) ? r_match : r_match + 4'd1;
  assign w_match_next = ((r_state == StUnlocked) || !w_cand_eq) ? 4'd1 : w_match_inc;
  assign w_lock_now   = (w_match_next >= LOCK_COUNT[3:0]);

  always_ff @(posedge i_clk_pixel) begin
    if (i_reset) begin
      r_state     <= StUnlocked;
      r_cand_n    <= '0;
      r_cand_cts  <= '0;
      r_match     <= '0;
      r_timeout   <= '0;
      r_n_out     <= '0;
      r_cts_out   <= '0;
      r_locked    <= 1'b0;
      r_acr_error <= 1'b0;
    end else begin
      r_acr_error <= w_is_acr && w_malformed;
      if (w_is_acr && w_malformed) begin
        r_match <= '0;
      end
      if (w_pkt_ok) begin
        r_timeout <= '0;
        case (r_state)
          StLocked: begin
            if (w_in_tol) begin
              r_cts_out <= w_cts;
            end else begin
              r_state    <= StAcquire;
              r_locked   <= 1'b0;
              r_cand_n   <= w_n;
              r_cand_cts <= w_cts;
              r_match    <= 4'd1;
            end
          end
          default: begin
            r_cand_n   <= w_n;
            r_cand_cts <= w_cts;
            r_match    <= w_match_next;
            if (w_lock_now) begin
              r_state   <= StLocked;
              r_locked  <= 1'b1;
              r_n_out   <= w_n;
              r_cts_out <= w_cts;
            end else begin
              r_state <= StAcquire;
            end
          end
        endcase
      end else if (w_timeout) begin
        r_state  <= StUnlocked;
        r_locked <= 1'b0;
        r_match  <= '0;
      end else begin
        r_timeout <= r_timeout + TO_W'(1);
      end
    end
  end

  assign w_sum     = {1'b0, r_acc} + {1'b0, r_n_out};
  assign w_sum_sub = w_sum - {1'b0, r_cts_out};

  // One subtraction per cycle is enough because n_out < cts_out.
  always_ff @(posedge i_clk_pixel) begin
    if (i_reset || !r_locked) begin
      r_acc          <= '0;
      r_div          <= '0;
      r_clk_audio_en <= 1'b0;
      r_sample_en    <= 1'b0;
    end else if (w_sum >= {1'b0, r_cts_out}) begin
      r_acc          <= w_sum_sub[19:0];
      r_div          <= r_div + 7'd1;
      r_clk_audio_en <= 1'b1;
      r_sample_en    <= (r_div == 7'd127);
    end else begin
      r_acc          <= w_sum[19:0];
      r_clk_audio_en <= 1'b0;
      r_sample_en    <= 1'b0;
    end
  end

  assign o_n_out        = r_n_out;
  assign o_cts_out      = r_cts_out;
  assign o_locked       = r_locked;
  assign o_acr_error    = r_acr_error;
  assign o_clk_audio_en = r_clk_audio_en;
  assign o_sample_en    = r_sample_en;

endmodule

// File: tb/tb_hdmi_acr_receiver.sv
// Self-checking bench for hdmi_acr_receiver: directed scenarios plus randomized packets,
// checked every cycle against a transaction-level model of the lock rules.
module tb_hdmi_acr_receiver;

  localparam int unsigned LC  = 2;
  localparam int unsigned TOL = 2;
  localparam int unsigned TC  = 25300;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] n_out, cts_out;
  logic        locked, acr_error, clk_audio_en, sample_en;

  always #5 clk = ~clk;

  hdmi_acr_if pkt_if ();

  hdmi_acr_receiver #(
    .LOCK_COUNT     (LC),
    .CTS_TOLERANCE  (TOL),
    .TIMEOUT_CYCLES (TC)
  ) u_dut (
    .i_clk_pixel    (clk),
    .i_reset        (rst),
    .i_pkt          (pkt_if),
    .o_n_out        (n_out),
    .o_cts_out      (cts_out),
    .o_locked       (locked),
    .o_acr_error    (acr_error),
    .o_clk_audio_en (clk_audio_en),
    .o_sample_en    (sample_en)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: 0 = unlocked, 1 = acquiring, 2 = locked
  int m_state, m_cn, m_cc, m_match, m_n, m_c, m_to;
  bit m_err;
  // Transaction presented at the coming edge
  bit t_rst, t_acr, t_bad;
  int t_n, t_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] mk_sub(input int n, input int c);
    logic [55:0] s;
    logic [19:0] nn, cc;
    nn = n[19:0];
    cc = c[19:0];
    s = '0;
    s[55:48] = nn[7:0];
    s[47:40] = nn[15:8];
    s[35:32] = nn[19:16];
    s[31:24] = cc[7:0];
    s[23:16] = cc[15:8];
    s[11:8]  = cc[19:16];
    return s;
  endfunction

  task automatic model_step();
    int d;
    if (t_rst) begin
      m_state = 0; m_cn = 0; m_cc = 0; m_match = 0; m_n = 0; m_c = 0; m_to = 0; m_err = 0;
      return;
    end
    m_err = t_acr && t_bad;
    if (m_err) m_match = 0;
    if (t_acr && !t_bad) begin
      m_to = 0;
      if (m_state == 2) begin
        d = t_c - m_c;
        if (d < 0) d = -d;
        if (t_n == m_n && d <= int'(TOL)) m_c = t_c;
        else begin
          m_state = 1; m_cn = t_n; m_cc = t_c; m_match = 1;
        end
      end else begin
        if (m_state == 1 && t_n == m_cn && t_c == m_cc) m_match = (m_match < 15) ? m_match + 1 : 15;
        else begin
          m_cn = t_n; m_cc = t_c; m_match = 1;
        end
        if (m_match >= int'(LC)) begin
          m_state = 2; m_n = m_cn; m_c = m_cc;
        end else m_state = 1;
      end
    end else if (m_to == int'(TC) - 1) begin
      m_state = 0; m_match = 0;
    end else m_to++;
  endtask

  task automatic tick();
    bit prev_locked;
    prev_locked = (m_state == 2);
    @(posedge clk);
    #1;
    model_step();
    check("locked", 32'(locked), 32'(m_state == 2));
    check("n_out", 32'(n_out), m_n);
    check("cts_out", 32'(cts_out), m_c);
    check("acr_error", 32'(acr_error), 32'(m_err));
    if (!prev_locked) begin
      check("audio_en_idle", 32'(clk_audio_en), 0);
      check("sample_en_idle", 32'(sample_en), 0);
    end
  endtask

  // One cycle with the given packet (pv = 0 means no packet).
  task automatic cyc(input bit pv, input logic [7:0] hb0, input int n, input int c,
                     input int diff, input logic [55:0] resv);
    logic [55:0] sp;
    logic [3:0][55:0] s4;
    sp = mk_sub(n, c) | resv;
    s4 = {4{sp}};
    if (diff != 0) s4[diff] = sp ^ (56'd1 << $urandom_range(0, 55));
    pkt_if.packet_valid = pv;
    pkt_if.header       = {8'($urandom), 8'($urandom), hb0};
    pkt_if.sub          = s4;
    t_acr = pv && (hb0 == 8'h01);
    t_bad = (diff != 0) || (resv != '0) || (n == 0) || (c == 0) || (n >= c);
    t_n = n;
    t_c = c;
    tick();
    pkt_if.packet_valid = 1'b0;
    t_acr = 1'b0;
  endtask

  task automatic acr(input int n, input int c);
    cyc(1'b1, 8'h01, n, c, 0, '0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 8'h00, 0, 0, 0, '0);
  endtask

  initial begin
    int k, pulses, samples, first_k, r, n, c;
    longint q, qp;
    bit exp_en, exp_s;

    pkt_if.packet_valid = 1'b0;
    pkt_if.header = '0;
    pkt_if.sub = '0;
    t_acr = 0; t_bad = 0; t_n = 0; t_c = 0;

    // Reset, with a packet in flight that must be discarded
    rst = 1'b1; t_rst = 1'b1;
    cyc(1'b1, 8'h01, 6144, 25200, 0, '0);
    cyc(1'b1, 8'h01, 6144, 25200, 0, '0);
    rst = 1'b0; t_rst = 1'b0;
    idle(10);
    check("reset_locked", 32'(locked), 0);
    check("reset_n", 32'(n_out), 0);

    // Lock sequence with a wrong-HB0 packet in between
    acr(6144, 25200);
    check("first_pkt_no_lock", 32'(locked), 0);
    idle(20);
    cyc(1'b1, 8'h02, 6144, 25200, 0, '0);
    check("hb0_no_error", 32'(acr_error), 0);
    check("hb0_no_lock", 32'(locked), 0);
    idle(3);
    acr(6144, 25200);
    check("lock_rise", 32'(locked), 1);
    check("lock_n", 32'(n_out), 6144);
    check("lock_cts", 32'(cts_out), 25200);

    // Regenerated rate: pulse k occurs when floor(k*N/CTS) steps up
    pulses = 0; samples = 0; first_k = -1;
    for (k = 1; k <= 25200; k++) begin
      idle(1);
      q  = (longint'(k) * 6144) / 25200;
      qp = (longint'(k - 1) * 6144) / 25200;
      exp_en = (q != qp);
      exp_s  = exp_en && (q % 128 == 0);
      check("audio_en", 32'(clk_audio_en), 32'(exp_en));
      check("sample_en", 32'(sample_en), 32'(exp_s));
      if (clk_audio_en) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (sample_en) samples++;
    end
    check("pulse_count", pulses, 6144);
    check("sample_count", samples, 48);
    check("first_pulse", first_k, 5);

    // Packet in the exact timeout cycle keeps lock
    idle(int'(TC) - 1 - 25200);
    check("pre_timeout_locked", 32'(locked), 1);
    acr(6144, 25200);
    check("timeout_pkt_wins", 32'(locked), 1);

    // Tolerance tracking and out-of-tolerance relock
    acr(6144, 25201);
    check("tol_plus", 32'(cts_out), 25201);
    idle(2);
    acr(6144, 25199);
    check("tol_minus", 32'(cts_out), 25199);
    check("tol_locked", 32'(locked), 1);
    acr(6144, 25210);
    check("out_tol_drop", 32'(locked), 0);
    acr(6144, 25210);
    check("relock", 32'(locked), 1);
    check("relock_cts", 32'(cts_out), 25210);

    // Malformed packets while locked: error pulse, lock untouched
    cyc(1'b1, 8'h01, 6144, 25210, 0, 56'h5A);
    check("bad_locked_err", 32'(acr_error), 1);
    check("bad_locked_keep", 32'(locked), 1);

    // Malformed packets while acquiring clear the match count
    acr(6144, 25300);
    for (int kind = 0; kind < 4; kind++) begin
      case (kind)
        0: cyc(1'b1, 8'h01, 6144, 25300, 2, '0);
        1: cyc(1'b1, 8'h01, 6144, 25300, 0, 56'h5A);
        2: cyc(1'b1, 8'h01, 0, 25300, 0, '0);
        default: cyc(1'b1, 8'h01, 30000, 25200, 0, '0);
      endcase
      check("bad_err", 32'(acr_error), 1);
      idle(1);
      check("bad_err_pulse", 32'(acr_error), 0);
      acr(6144, 25300);
      check("bad_cleared_match", 32'(locked), 0);
    end
    acr(6144, 25300);
    check("relock_after_bad", 32'(locked), 1);

    // Randomized packet mix against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      n = ($urandom_range(0, 1) == 1) ? 6144 : 4096;
      c = ((n == 6144) ? 25200 : 27000) +
          (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0);
      if (r <= 3) idle(1);
      else if (r <= 6) acr(n, c);
      else if (r == 7) begin
        case ($urandom_range(0, 3))
          0: cyc(1'b1, 8'h01, n, c, int'($urandom_range(1, 3)), '0);
          1: cyc(1'b1, 8'h01, n, c, 0, ($urandom_range(0, 1) == 1) ?
                 56'($urandom_range(1, 255)) : (56'($urandom_range(1, 15)) << 36));
          2: cyc(1'b1, 8'h01, 0, c, 0, '0);
          default: cyc(1'b1, 8'h01, c, n, 0, '0);
        endcase
      end else if (r == 8) cyc(1'b1, 8'($urandom_range(2, 255)), n, c, 0, '0);
      else acr(int'($urandom_range(0, 1048575)), int'($urandom_range(0, 1048575)));
    end

    // Timeout drops lock and stops regeneration
    acr(4096, 27000);
    acr(4096, 27000);
    check("pre_to_lock", 32'(locked), 1);
    idle(int'(TC) - 1);
    check("to_still_locked", 32'(locked), 1);
    idle(1);
    check("to_dropped", 32'(locked), 0);
    idle(3);
    check("to_audio_stop", 32'(clk_audio_en), 0);
    check("to_sample_stop", 32'(sample_en), 0);

    // Mid-operation reset discards an in-flight packet
    acr(6144, 25200);
    acr(6144, 25200);
    rst = 1'b1; t_rst = 1'b1;
    cyc(1'b1, 8'h01, 6144, 25200, 0, '0);
    rst = 1'b0; t_rst = 1'b0;
    check("midreset_locked", 32'(locked), 0);
    check("midreset_cts", 32'(cts_out), 0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
